// File: rtl/bc_msg_pkg.sv
// Shared defaults and message field layout for the broadcast message arbiter.
// A message is {data[31:0], strb[3:0], word_addr[10:0]}, word_addr in the LSBs.
package bc_msg_pkg;

  localparam int BC_CORE_COUNT = 16;
  localparam int BC_MSG_WIDTH  = 47;

  localparam int BC_ADDR_LSB   = 0;
  localparam int BC_ADDR_WIDTH = 11;
  localparam int BC_STRB_LSB   = BC_ADDR_LSB + BC_ADDR_WIDTH;
  localparam int BC_STRB_WIDTH = 4;
  localparam int BC_DATA_LSB   = BC_STRB_LSB + BC_STRB_WIDTH;
  localparam int BC_DATA_WIDTH = 32;

  typedef struct packed {
    logic [BC_DATA_WIDTH-1:0] data;
    logic [BC_STRB_WIDTH-1:0] strb;
    logic [BC_ADDR_WIDTH-1:0] word_addr;
  } bc_msg_t;

  function automatic logic [BC_MSG_WIDTH-1:0] bc_msg_pack(
    input logic [BC_DATA_WIDTH-1:0] data,
    input logic [BC_STRB_WIDTH-1:0] strb,
    input logic [BC_ADDR_WIDTH-1:0] word_addr
  );
    bc_msg_t m;
    m.data      = data;
    m.strb      = strb;
    m.word_addr = word_addr;
    return m;
  endfunction

endpackage

// File: rtl/bc_msg_arbiter_rr_arbiter.sv
// Round-robin selector: the first set request at or above ptr_i (wrapping
// modulo N) wins; produces a one-hot grant and the winner's index.
module rr_arbiter #(
  parameter int N     = 16,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic             grant_valid_o,
  output logic [IDX_W-1:0] winner_o
);

  localparam int SW = IDX_W + 1;

  logic [SW-1:0]    pos;
  logic [IDX_W-1:0] idx;

  // Walk the N candidates starting at the pointer; the first hit latches the grant.
  always_comb begin
    grant_o       = '0;
    grant_valid_o = 1'b0;
    winner_o      = '0;
    pos           = '0;
    idx           = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, ptr_i} + SW'(i);
      if (pos >= SW'(N)) begin
        pos = pos - SW'(N);
      end
      idx = pos[IDX_W-1:0];
      if (!grant_valid_o && req_i[idx]) begin
        grant_valid_o = 1'b1;
        winner_o      = idx;
        grant_o[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bc_msg_arbiter.sv
// Collects per-core outgoing messages, grants one enabled core per cycle in
// round-robin order and broadcasts it one cycle later; masked cores are drained.
module bc_msg_arbiter
  import bc_msg_pkg::*;
#(
  parameter int CORE_COUNT = BC_CORE_COUNT,
  parameter int MSG_WIDTH  = BC_MSG_WIDTH,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                            sys_clk,
  input  logic                            sys_rst_n,
  input  logic [CORE_COUNT*MSG_WIDTH-1:0] bc_msg_out,
  input  logic [CORE_COUNT-1:0]           bc_msg_out_valid,
  output logic [CORE_COUNT-1:0]           bc_msg_out_ready,
  input  logic [CORE_COUNT-1:0]           core_mask,
  output logic [MSG_WIDTH-1:0]            bc_msg_in,
  output logic                            bc_msg_in_valid,
  output logic [CNT_WIDTH-1:0]            bc_msg_count,
  output logic [CNT_WIDTH-1:0]            bc_drop_count
);

  localparam int IDX_W = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;
  localparam int PC_W  = $clog2(CORE_COUNT + 1);
  localparam int SUM_W = CNT_WIDTH + PC_W;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CORE_COUNT-1:0] req;
  logic [CORE_COUNT-1:0] drain;
  logic [CORE_COUNT-1:0] grant;
  logic                  grant_valid;
  logic [IDX_W-1:0]      winner;

  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [MSG_WIDTH-1:0] msg_q, msg_d;
  logic                 msg_valid_q, msg_valid_d;
  logic [CNT_WIDTH-1:0] msg_count_q, msg_count_d;
  logic [CNT_WIDTH-1:0] drop_count_q, drop_count_d;
  logic [PC_W-1:0]      drop_pop;
  logic [SUM_W-1:0]     drop_sum;

  // Reset gates both paths so nothing is accepted or drained while held in reset.
  assign req   = bc_msg_out_valid &  core_mask & {CORE_COUNT{sys_rst_n}};
  assign drain = bc_msg_out_valid & ~core_mask & {CORE_COUNT{sys_rst_n}};
  assign bc_msg_out_ready = grant | drain;

  rr_arbiter #(
    .N     (CORE_COUNT),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req_i         (req),
    .ptr_i         (rr_ptr_q),
    .grant_o       (grant),
    .grant_valid_o (grant_valid),
    .winner_o      (winner)
  );

  always_comb begin
    drop_pop = '0;
    for (int i = 0; i < CORE_COUNT; i++) begin
      drop_pop = drop_pop + PC_W'(drain[i]);
    end
    // Widened sum so a multi-core drop near the top still saturates instead of wrapping.
    drop_sum     = SUM_W'(drop_count_q) + SUM_W'(drop_pop);
    drop_count_d = (drop_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : drop_sum[CNT_WIDTH-1:0];

    rr_ptr_d    = rr_ptr_q;
    msg_d       = msg_q;
    msg_valid_d = grant_valid;
    msg_count_d = msg_count_q;
    if (grant_valid) begin
      msg_d    = bc_msg_out[int'(winner)*MSG_WIDTH +: MSG_WIDTH];
      rr_ptr_d = (int'(winner) == CORE_COUNT - 1) ? '0 : winner + IDX_W'(1);
      if (msg_count_q != CNT_MAX) begin
        msg_count_d = msg_count_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rr_ptr_q     <= '0;
      msg_q        <= '0;
      msg_valid_q  <= 1'b0;
      msg_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      msg_q        <= msg_d;
      msg_valid_q  <= msg_valid_d;
      msg_count_q  <= msg_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign bc_msg_in       = msg_q;
  assign bc_msg_in_valid = msg_valid_q;
  assign bc_msg_count    = msg_count_q;
  assign bc_drop_count   = drop_count_q;

endmodule

// File: tb/tb_bc_msg_arbiter.sv
// Directed bench for bc_msg_arbiter: a 32-bit-counter instance and a 4-bit-counter
// instance share the same stimulus so counter saturation is observed alongside.
module tb_bc_msg_arbiter;
  import bc_msg_pkg::*;

  localparam int NC = 16;
  localparam int MW = 47;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic [NC*MW-1:0]  bc_msg_out;
  logic [NC-1:0]     bc_msg_out_valid;
  logic [NC-1:0]     core_mask;
  logic [NC-1:0]     ready, ready_s;
  logic [MW-1:0]     msg_in, msg_in_s;
  logic              msg_in_valid, msg_in_valid_s;
  logic [31:0]       msg_count, drop_count;
  logic [3:0]        msg_count_s, drop_count_s;

  int checks   = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;

  bc_msg_arbiter #(.CORE_COUNT(NC), .MSG_WIDTH(MW), .CNT_WIDTH(32)) dut (
    .sys_clk          (sys_clk),
    .sys_rst_n        (sys_rst_n),
    .bc_msg_out       (bc_msg_out),
    .bc_msg_out_valid (bc_msg_out_valid),
    .bc_msg_out_ready (ready),
    .core_mask        (core_mask),
    .bc_msg_in        (msg_in),
    .bc_msg_in_valid  (msg_in_valid),
    .bc_msg_count     (msg_count),
    .bc_drop_count    (drop_count)
  );

  bc_msg_arbiter #(.CORE_COUNT(NC), .MSG_WIDTH(MW), .CNT_WIDTH(4)) dut_small (
    .sys_clk          (sys_clk),
    .sys_rst_n        (sys_rst_n),
    .bc_msg_out       (bc_msg_out),
    .bc_msg_out_valid (bc_msg_out_valid),
    .bc_msg_out_ready (ready_s),
    .core_mask        (core_mask),
    .bc_msg_in        (msg_in_s),
    .bc_msg_in_valid  (msg_in_valid_s),
    .bc_msg_count     (msg_count_s),
    .bc_drop_count    (drop_count_s)
  );

  function automatic logic [MW-1:0] core_msg(input int i);
    return bc_msg_pack(32'hD000_0000 + 32'(i), 4'(i) ^ 4'hA, 11'(i * 7));
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NC-1:0] valid, input logic [NC-1:0] mask);
    bc_msg_out_valid = valid;
    core_mask        = mask;
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < NC; i++) bc_msg_out[i*MW +: MW] = core_msg(i);

    // Reset held: valid cores, some masked, yet nothing accepted or drained.
    sys_rst_n = 1'b0;
    applyStimulus(16'hFFFF, 16'h00FF);
    #2;
    checkOutput("rst_ready", 64'(ready), 64'h0);
    checkOutput("rst_valid", 64'(msg_in_valid), 64'h0);
    checkOutput("rst_msg", 64'(msg_in), 64'h0);
    tick();
    checkOutput("rst_ready_edge", 64'(ready), 64'h0);
    checkOutput("rst_count", 64'(msg_count), 64'h0);
    checkOutput("rst_drop", 64'(drop_count), 64'h0);
    sys_rst_n = 1'b1;

    // Cores 2 and 9 valid: back-to-back grants 2 then 9.
    applyStimulus(16'h0204, 16'hFFFF);
    #1;
    checkOutput("pair_ready2", 64'(ready), 64'h0004);
    tick();
    checkOutput("pair_valid2", 64'(msg_in_valid), 64'h1);
    checkOutput("pair_msg2", 64'(msg_in), 64'(core_msg(2)));
    applyStimulus(16'h0200, 16'hFFFF);
    #1;
    checkOutput("pair_ready9", 64'(ready), 64'h0200);
    tick();
    checkOutput("pair_valid9", 64'(msg_in_valid), 64'h1);
    checkOutput("pair_msg9", 64'(msg_in), 64'(core_msg(9)));
    applyStimulus(16'h0000, 16'hFFFF);
    tick();
    checkOutput("idle_valid", 64'(msg_in_valid), 64'h0);
    checkOutput("idle_hold", 64'(msg_in), 64'(core_msg(9)));
    checkOutput("pair_count", 64'(msg_count), 64'd2);

    // Fresh reset so the pointer starts at 0 for the full-load run.
    sys_rst_n = 1'b0;
    #1;
    checkOutput("rst2_count", 64'(msg_count), 64'h0);
    sys_rst_n = 1'b1;

    for (int c = 0; c < 32; c++) begin
      applyStimulus(16'hFFFF, 16'hFFFF);
      #1;
      checkOutput($sformatf("full_ready_%0d", c), 64'(ready), 64'(16'h1 << (c % 16)));
      tick();
      checkOutput($sformatf("full_valid_%0d", c), 64'(msg_in_valid), 64'h1);
      checkOutput($sformatf("full_msg_%0d", c), 64'(msg_in), 64'(core_msg(c % 16)));
    end
    checkOutput("full_count", 64'(msg_count), 64'd32);
    checkOutput("sat_count_small", 64'(msg_count_s), 64'd15);

    // Last grant was core 15: core 0 wins over 14 through the wrap.
    applyStimulus(16'h4001, 16'hFFFF);
    #1;
    checkOutput("wrap_ready0", 64'(ready), 64'h0001);
    tick();
    checkOutput("wrap_msg0", 64'(msg_in), 64'(core_msg(0)));
    applyStimulus(16'h4000, 16'hFFFF);
    #1;
    checkOutput("wrap_ready14", 64'(ready), 64'h4000);
    tick();
    checkOutput("wrap_msg14", 64'(msg_in), 64'(core_msg(14)));

    // Masked core 5 is drained for 4 cycles without any broadcast.
    for (int c = 0; c < 4; c++) begin
      applyStimulus(16'h0020, 16'hFFDF);
      #1;
      checkOutput($sformatf("drain_ready_%0d", c), 64'(ready), 64'h0020);
      tick();
      checkOutput($sformatf("drain_valid_%0d", c), 64'(msg_in_valid), 64'h0);
    end
    checkOutput("drain_count", 64'(drop_count), 64'd4);
    checkOutput("drain_hold", 64'(msg_in), 64'(core_msg(14)));

    // Drain and grant together; the drained core must not move the pointer.
    applyStimulus(16'h00A0, 16'hFFDF);
    #1;
    checkOutput("mix_ready", 64'(ready), 64'h00A0);
    tick();
    checkOutput("mix_msg7", 64'(msg_in), 64'(core_msg(7)));
    checkOutput("mix_drop", 64'(drop_count), 64'd5);
    applyStimulus(16'h0240, 16'hFFFF);
    #1;
    checkOutput("ptr_ready9", 64'(ready), 64'h0200);
    tick();
    checkOutput("ptr_msg9", 64'(msg_in), 64'(core_msg(9)));
    checkOutput("mix_count", 64'(msg_count), 64'd36);

    // Every core masked and valid: all drained at once, small drop counter saturates.
    applyStimulus(16'hFFFF, 16'h0000);
    #1;
    checkOutput("allmask_ready", 64'(ready), 64'hFFFF);
    tick();
    checkOutput("allmask_valid", 64'(msg_in_valid), 64'h0);
    checkOutput("allmask_drop", 64'(drop_count), 64'd21);
    checkOutput("sat_drop_small", 64'(drop_count_s), 64'd15);

    // Asynchronous reset mid-burst, asserted between clock edges.
    applyStimulus(16'hFFFF, 16'hFFFF);
    tick();
    tick();
    #2;
    sys_rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", 64'(msg_in_valid), 64'h0);
    checkOutput("arst_msg", 64'(msg_in), 64'h0);
    checkOutput("arst_count", 64'(msg_count), 64'h0);
    checkOutput("arst_drop", 64'(drop_count), 64'h0);
    checkOutput("arst_ready", 64'(ready), 64'h0);
    tick();
    checkOutput("arst_ready_held", 64'(ready), 64'h0);
    checkOutput("arst_valid_held", 64'(msg_in_valid), 64'h0);
    sys_rst_n = 1'b1;
    #1;
    checkOutput("release_ready", 64'(ready), 64'h0001);
    tick();
    checkOutput("release_msg", 64'(msg_in), 64'(core_msg(0)));
    checkOutput("release_count", 64'(msg_count), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
